// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants, event layout and deframer state encoding for
// the PS/2 keyboard receiver.
//   PS2_EXT / PS2_BRK : prefix bytes for extended keys and key release
//   ps2_event_t       : 16-bit queued event {ext, brk, pad, code}
//   ps2_state_t       : deframer FSM states
package ps2_pkg;

   localparam logic [7:0] PS2_EXT = 8'hE0;
   localparam logic [7:0] PS2_BRK = 8'hF0;

   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [5:0] pad;
      logic [7:0] code;
   } ps2_event_t;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ps2_state_t;

endpackage

// File: rtl/ps2_rx_fifo_if.sv
// ps2_rx_fifo_if: CPU-side bus of the PS/2 receiver.
//   rd        : pop strobe from the CPU
//   clr       : clears overflow and err_count
//   rdata     : FIFO head event, zero when empty
//   irq       : high while events are pending
//   count     : number of queued events
//   overflow  : sticky drop flag
//   err_count : saturating error counter
//
// Handshake: rdata is valid whenever irq is high. A one-cycle rd while irq
// is high consumes the head; the next entry (or zero) appears on rdata on
// the following cycle. rd while irq is low is ignored. There is no ready
// towards the keyboard side: a completed event arriving while the FIFO is
// full and not being popped is dropped and recorded in overflow.
interface ps2_rx_fifo_if
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH = 8
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic          rd;
   logic          clr;
   ps2_event_t    rdata;
   logic          irq;
   logic [CW-1:0] count;
   logic          overflow;
   logic [7:0]    err_count;

   modport master (
      output rd, clr,
      input  rdata, irq, count, overflow, err_count
   );

   modport slave (
      input  rd, clr,
      output rdata, irq, count, overflow, err_count
   );

endinterface

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: 2-flop synchroniser, FILTER_LEN-deep majority-free
// glitch filter and registered falling-edge strobe for one PS/2 line.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   raw   : asynchronous line input
//   fall  : one-cycle strobe on each filtered falling edge
module ps2_line_filter #(
   parameter int FILTER_LEN = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic fall
);

   logic [1:0]            sync;
   logic [FILTER_LEN-1:0] sr;
   logic                  filt;

   // Everything resets high (idle bus) so releasing reset never looks
   // like a falling edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync <= 2'b11;
         sr   <= '1;
         filt <= 1'b1;
         fall <= 1'b0;
      end else begin
         sync <= {sync[0], raw};
         sr   <= {sr[FILTER_LEN-2:0], sync[1]};
         if (&sr)
            filt <= 1'b1;
         else if (~|sr)
            filt <= 1'b0;
         // Strobe in the same cycle the filtered level drops.
         fall <= filt & ~|sr;
      end
   end

endmodule

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 keyboard receiver with E0/F0 prefix folding and a
// first-word-fall-through event FIFO on the CPU bus.
//   CLOCK_50  : system clock
//   reset     : asynchronous active-low reset
//   pc, pd    : raw PS/2 clock and data
//   bus       : CPU bus (rd, clr, rdata, irq, count, overflow, err_count)
//   fsm_state : current deframer state
module ps2_rx_fifo
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN     = 16,
   parameter int FIFO_DEPTH     = 8,
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int REPORT_BREAK   = 1
) (
   input  logic               CLOCK_50,
   input  logic               reset,
   input  logic               pc,
   input  logic               pd,
   ps2_rx_fifo_if.slave       bus,
   output ps2_state_t         fsm_state
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic          fall;
   logic [1:0]    pd_sync;
   logic          pd_s;

   ps2_state_t    state;
   logic [3:0]    bit_cnt;
   logic [7:0]    shreg;
   logic          par;
   logic          ext;
   logic          brk;
   logic [TW-1:0] idle_cnt;

   ps2_event_t    mem [FIFO_DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [CW-1:0] cnt;
   logic          overflow;
   logic [7:0]    err_count;

   logic          byte_done;
   logic          frame_ok;
   logic          start_err;
   logic          timeout;
   logic          err_inc;
   logic          is_prefix;
   logic          push;
   logic          pop;
   logic          full;
   logic          wr_en;
   ps2_event_t    ev;

   ps2_line_filter #(
      .FILTER_LEN(FILTER_LEN)
   ) u_pc_filter (
      .clk  (CLOCK_50),
      .rst_n(reset),
      .raw  (pc),
      .fall (fall)
   );

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset)
         pd_sync <= 2'b11;
      else
         pd_sync <= {pd_sync[0], pd};
   end
   assign pd_s = pd_sync[1];

   always_comb begin
      byte_done = fall && (state == SHIFT) && (bit_cnt == 4'd10);
      // Data plus parity must carry an odd number of ones; stop must be 1.
      frame_ok  = (^{shreg, par}) && pd_s;
      start_err = fall && (state == IDLE) && pd_s;
      timeout   = (state == SHIFT) && !fall && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
      err_inc   = start_err || (byte_done && !frame_ok) || timeout;
      is_prefix = (shreg == PS2_EXT) || (shreg == PS2_BRK);
      ev        = {ext, brk, 6'b0, shreg};
      push      = byte_done && frame_ok && !is_prefix && ((REPORT_BREAK != 0) || !brk);
      pop       = bus.rd && (cnt != '0);
      full      = (cnt == CW'(FIFO_DEPTH));
      wr_en     = push && (!full || pop);
   end

   // Deframer and prefix folding.
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         bit_cnt  <= 4'd0;
         shreg    <= 8'd0;
         par      <= 1'b0;
         ext      <= 1'b0;
         brk      <= 1'b0;
         idle_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               idle_cnt <= '0;
               if (fall && !pd_s) begin
                  state   <= SHIFT;
                  bit_cnt <= 4'd1;
               end
            end
            SHIFT: begin
               if (fall) begin
                  idle_cnt <= '0;
                  if (bit_cnt <= 4'd8)
                     shreg <= {pd_s, shreg[7:1]};
                  else if (bit_cnt == 4'd9)
                     par <= pd_s;
                  if (bit_cnt == 4'd10) begin
                     state   <= IDLE;
                     bit_cnt <= 4'd0;
                     if (frame_ok && shreg == PS2_EXT)
                        ext <= 1'b1;
                     else if (frame_ok && shreg == PS2_BRK)
                        brk <= 1'b1;
                     else begin
                        // Completed event or bad frame: both drop the prefixes.
                        ext <= 1'b0;
                        brk <= 1'b0;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 4'd1;
                  end
               end else if (timeout) begin
                  state    <= IDLE;
                  bit_cnt  <= 4'd0;
                  ext      <= 1'b0;
                  brk      <= 1'b0;
                  idle_cnt <= '0;
               end else begin
                  idle_cnt <= idle_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // FIFO storage needs no reset: rdata is forced to zero while empty.
   always_ff @(posedge CLOCK_50) begin
      if (wr_en)
         mem[wptr] <= ev;
   end

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         wptr      <= '0;
         rptr      <= '0;
         cnt       <= '0;
         overflow  <= 1'b0;
         err_count <= 8'd0;
      end else begin
         if (wr_en)
            wptr <= wptr + 1'b1;
         if (pop)
            rptr <= rptr + 1'b1;
         case ({wr_en, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
         // A drop in the same cycle as clr still leaves overflow set.
         if (push && full && !pop)
            overflow <= 1'b1;
         else if (bus.clr)
            overflow <= 1'b0;
         if (bus.clr)
            err_count <= err_inc ? 8'd1 : 8'd0;
         else if (err_inc && err_count != 8'hFF)
            err_count <= err_count + 8'd1;
      end
   end

   assign bus.rdata     = (cnt == '0) ? '0 : mem[rptr];
   assign bus.irq       = (cnt != '0);
   assign bus.count     = cnt;
   assign bus.overflow  = overflow;
   assign bus.err_count = err_count;
   assign fsm_state     = state;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: bench for ps2_rx_fifo with a keyboard-side frame driver
// and a queue-based model of the event FIFO and prefix rules.
module tb_ps2_rx_fifo;
   import ps2_pkg::*;

   localparam int FL    = 8;
   localparam int DEPTH = 4;
   localparam int TO    = 200;
   localparam int HALF  = 30;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       pc    = 1'b1;
   logic       pd    = 1'b1;
   ps2_state_t st;
   ps2_state_t st_nb;

   int total = 0;
   int bad   = 0;

   logic [15:0] exp_q[$];
   bit          m_ext;
   bit          m_brk;
   bit          m_ovf;
   int          m_err;

   always #5 clk = ~clk;

   ps2_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();
   ps2_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus_nb ();

   ps2_rx_fifo #(
      .FILTER_LEN(FL), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO), .REPORT_BREAK(1)
   ) dut (
      .CLOCK_50(clk), .reset(rst_n), .pc(pc), .pd(pd), .bus(bus), .fsm_state(st)
   );

   ps2_rx_fifo #(
      .FILTER_LEN(FL), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO), .REPORT_BREAK(0)
   ) dut_nb (
      .CLOCK_50(clk), .reset(rst_n), .pc(pc), .pd(pd), .bus(bus_nb), .fsm_state(st_nb)
   );

   // ---------------- model ----------------
   function automatic logic [15:0] exp_head();
      return (exp_q.size() > 0) ? exp_q[0] : 16'h0000;
   endfunction

   task automatic model_clear();
      exp_q.delete();
      m_ext = 0; m_brk = 0; m_ovf = 0; m_err = 0;
   endtask

   task automatic model_err();
      if (m_err < 255) m_err++;
   endtask

   task automatic model_frame(input logic [7:0] b, input bit ok);
      if (!ok) begin
         model_err();
         m_ext = 0; m_brk = 0;
      end else if (b == 8'hE0) begin
         m_ext = 1;
      end else if (b == 8'hF0) begin
         m_brk = 1;
      end else begin
         if (exp_q.size() < DEPTH) exp_q.push_back({m_ext, m_brk, 6'b0, b});
         else m_ovf = 1;
         m_ext = 0; m_brk = 0;
      end
   endtask

   task automatic model_pop();
      if (exp_q.size() > 0) void'(exp_q.pop_front());
   endtask

   // ---------------- drivers ----------------
   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                             input int n_bits, input bit rd_at_stop);
      logic [10:0] bits;
      bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < n_bits; i++) begin
         pd = bits[i];
         repeat (HALF) @(negedge clk);
         pc = 1'b0;
         if (rd_at_stop && i == 10) begin
            // fall is high in the cycle after the 11th edge; pop in that cycle
            repeat (11) @(posedge clk);
            @(negedge clk); bus.rd = 1'b1;
            @(negedge clk); bus.rd = 1'b0;
            repeat (HALF - 2) @(negedge clk);
         end else begin
            repeat (HALF) @(negedge clk);
         end
         pc = 1'b1;
      end
      pd = 1'b1;
      repeat (20) @(negedge clk);
   endtask

   task automatic frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
      send_frame(b, bad_par, bad_stop, 11, 1'b0);
      model_frame(b, !bad_par && !bad_stop);
   endtask

   task automatic do_pop();
      bus.rd = 1'b1;
      @(negedge clk);
      bus.rd = 1'b0;
      model_pop();
      @(negedge clk);
   endtask

   task automatic do_clr();
      bus.clr = 1'b1; bus_nb.clr = 1'b1;
      @(negedge clk);
      bus.clr = 1'b0; bus_nb.clr = 1'b0;
      m_ovf = 0; m_err = 0;
      @(negedge clk);
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_clear();
      repeat (3) @(negedge clk);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (bus.count !== CW'(0)) begin bad++; $display("FAIL reset_count: got %0d want 0", bus.count); end
      total++; if (bus.irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", bus.irq); end
      total++; if (bus.rdata !== 16'h0000) begin bad++; $display("FAIL reset_rdata: got %h want 0000", bus.rdata); end
      total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", bus.overflow); end
      total++; if (bus.err_count !== 8'd0) begin bad++; $display("FAIL reset_err: got %0d want 0", bus.err_count); end
      total++; if (st !== IDLE) begin bad++; $display("FAIL reset_state: got %0d want IDLE", st); end
      rst_n = 1'b1;
      model_clear();
      repeat (5) @(negedge clk);
   endtask

   task automatic test_make();
      frame(8'h1C, 0, 0);
      total++; if (bus.irq !== 1'b1) begin bad++; $display("FAIL make_irq: got %b want 1", bus.irq); end
      total++; if (bus.rdata !== 16'h001C) begin bad++; $display("FAIL make_rdata: got %h want 001c", bus.rdata); end
      total++; if (bus.count !== CW'(1)) begin bad++; $display("FAIL make_count: got %0d want 1", bus.count); end
      do_pop();
      total++; if (bus.irq !== 1'b0) begin bad++; $display("FAIL make_pop_irq: got %b want 0", bus.irq); end
      total++; if (bus.rdata !== 16'h0000) begin bad++; $display("FAIL make_pop_rdata: got %h want 0000", bus.rdata); end
      total++; if (bus.count !== CW'(0)) begin bad++; $display("FAIL make_pop_count: got %0d want 0", bus.count); end
   endtask

   task automatic test_break();
      pulse_reset();
      frame(8'hE0, 0, 0);
      frame(8'hF0, 0, 0);
      frame(8'h74, 0, 0);
      total++; if (bus.rdata !== 16'hC074) begin bad++; $display("FAIL brk_rdata: got %h want c074", bus.rdata); end
      total++; if (bus.count !== CW'(1)) begin bad++; $display("FAIL brk_count: got %0d want 1", bus.count); end
      total++; if (bus_nb.irq !== 1'b0) begin bad++; $display("FAIL brk_nb_irq: got %b want 0", bus_nb.irq); end
      total++; if (bus_nb.count !== CW'(0)) begin bad++; $display("FAIL brk_nb_count: got %0d want 0", bus_nb.count); end
      frame(8'h1C, 0, 0);
      total++; if (bus_nb.rdata !== 16'h001C) begin bad++; $display("FAIL brk_nb_make: got %h want 001c", bus_nb.rdata); end
      total++; if (bus_nb.count !== CW'(1)) begin bad++; $display("FAIL brk_nb_make_count: got %0d want 1", bus_nb.count); end
      while (exp_q.size() > 0) begin
         total++; if (bus.rdata !== exp_head()) begin bad++; $display("FAIL brk_drain: got %h want %h", bus.rdata, exp_head()); end
         do_pop();
      end
   endtask

   task automatic test_errors();
      frame(8'h1C, 1, 0);
      frame(8'h1C, 0, 0);
      total++; if (bus.err_count !== 8'd1) begin bad++; $display("FAIL par_err: got %0d want 1", bus.err_count); end
      total++; if (bus.count !== CW'(1)) begin bad++; $display("FAIL par_count: got %0d want 1", bus.count); end
      total++; if (bus.rdata !== 16'h001C) begin bad++; $display("FAIL par_rdata: got %h want 001c", bus.rdata); end
      do_pop();
      frame(8'h1C, 0, 1);
      total++; if (bus.err_count !== 8'd2) begin bad++; $display("FAIL stop_err: got %0d want 2", bus.err_count); end
      total++; if (bus.count !== CW'(0)) begin bad++; $display("FAIL stop_count: got %0d want 0", bus.count); end
      // one clock pulse with data high: bad start bit
      pd = 1'b1; pc = 1'b0;
      repeat (HALF) @(negedge clk);
      pc = 1'b1;
      repeat (HALF) @(negedge clk);
      model_err();
      total++; if (bus.err_count !== 8'(m_err)) begin bad++; $display("FAIL start_err: got %0d want %0d", bus.err_count, m_err); end
      total++; if (st !== IDLE) begin bad++; $display("FAIL start_state: got %0d want IDLE", st); end
      do_clr();
      total++; if (bus.err_count !== 8'd0) begin bad++; $display("FAIL err_clr: got %0d want 0", bus.err_count); end
   endtask

   task automatic test_timeout();
      frame(8'hE0, 0, 0);
      send_frame(8'hAA, 0, 0, 4, 1'b0);
      total++; if (st !== SHIFT) begin bad++; $display("FAIL to_midframe_state: got %0d want SHIFT", st); end
      repeat (TO + 10) @(negedge clk);
      model_err();
      m_ext = 0; m_brk = 0;
      total++; if (st !== IDLE) begin bad++; $display("FAIL to_state: got %0d want IDLE", st); end
      total++; if (bus.err_count !== 8'(m_err)) begin bad++; $display("FAIL to_err: got %0d want %0d", bus.err_count, m_err); end
      frame(8'h74, 0, 0);
      total++; if (bus.rdata !== 16'h0074) begin bad++; $display("FAIL to_rdata: got %h want 0074", bus.rdata); end
      total++; if (bus.err_count !== 8'd1) begin bad++; $display("FAIL to_err_after: got %0d want 1", bus.err_count); end
      do_pop();
   endtask

   task automatic test_overflow();
      do_clr();
      for (int i = 0; i <= DEPTH; i++) frame(8'h10 + 8'(i), 0, 0);
      total++; if (bus.count !== CW'(DEPTH)) begin bad++; $display("FAIL ovf_count: got %0d want %0d", bus.count, DEPTH); end
      total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", bus.overflow); end
      for (int i = 0; i < DEPTH; i++) begin
         total++; if (bus.rdata !== {8'h00, 8'h10 + 8'(i)}) begin bad++; $display("FAIL ovf_entry%0d: got %h want %h", i, bus.rdata, 8'h10 + 8'(i)); end
         do_pop();
      end
      total++; if (bus.irq !== 1'b0) begin bad++; $display("FAIL ovf_drained_irq: got %b want 0", bus.irq); end
      do_clr();
      total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL ovf_clr: got %b want 0", bus.overflow); end
      for (int i = 0; i < DEPTH; i++) frame(8'h20 + 8'(i), 0, 0);
      total++; if (bus.rdata !== 16'h0020) begin bad++; $display("FAIL ovf_pp_head: got %h want 0020", bus.rdata); end
      send_frame(8'h20 + 8'(DEPTH), 0, 0, 11, 1'b1);
      model_pop();
      model_frame(8'h20 + 8'(DEPTH), 1'b1);
      total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL ovf_pp_flag: got %b want 0", bus.overflow); end
      total++; if (bus.count !== CW'(DEPTH)) begin bad++; $display("FAIL ovf_pp_count: got %0d want %0d", bus.count, DEPTH); end
      while (exp_q.size() > 0) begin
         total++; if (bus.rdata !== exp_head()) begin bad++; $display("FAIL ovf_pp_drain: got %h want %h", bus.rdata, exp_head()); end
         do_pop();
      end
   endtask

   task automatic test_saturate();
      do_clr();
      for (int i = 0; i < 260; i++) begin
         pc = 1'b0;
         repeat (FL + 4) @(negedge clk);
         pc = 1'b1;
         repeat (FL + 4) @(negedge clk);
         model_err();
      end
      total++; if (bus.err_count !== 8'(m_err)) begin bad++; $display("FAIL sat_err: got %0d want %0d", bus.err_count, m_err); end
      total++; if (bus.err_count !== 8'd255) begin bad++; $display("FAIL sat_255: got %0d want 255", bus.err_count); end
      do_clr();
      total++; if (bus.err_count !== 8'd0) begin bad++; $display("FAIL sat_clr: got %0d want 0", bus.err_count); end
   endtask

   task automatic test_reset_midframe();
      send_frame(8'h5A, 0, 0, 6, 1'b0);
      total++; if (st !== SHIFT) begin bad++; $display("FAIL mid_state: got %0d want SHIFT", st); end
      pulse_reset();
      total++; if (st !== IDLE) begin bad++; $display("FAIL mid_rst_state: got %0d want IDLE", st); end
      frame(8'h1C, 0, 0);
      total++; if (bus.count !== CW'(1)) begin bad++; $display("FAIL mid_count: got %0d want 1", bus.count); end
      total++; if (bus.rdata !== 16'h001C) begin bad++; $display("FAIL mid_rdata: got %h want 001c", bus.rdata); end
      total++; if (bus.err_count !== 8'd0) begin bad++; $display("FAIL mid_err: got %0d want 0", bus.err_count); end
      for (int i = 0; i < 4; i++) begin
         pc = 1'b0;
         repeat (3) @(negedge clk);
         pc = 1'b1;
         repeat (15) @(negedge clk);
      end
      total++; if (bus.err_count !== 8'd0) begin bad++; $display("FAIL glitch_err: got %0d want 0", bus.err_count); end
      total++; if (st !== IDLE) begin bad++; $display("FAIL glitch_state: got %0d want IDLE", st); end
      total++; if (bus.count !== CW'(1)) begin bad++; $display("FAIL glitch_count: got %0d want 1", bus.count); end
      do_pop();
   endtask

   task automatic test_random();
      logic [7:0] b;
      int         sel;
      int         npop;
      do_clr();
      for (int n = 0; n < 20; n++) begin
         sel = $urandom_range(0, 5);
         case (sel)
            0:       b = 8'hE0;
            1:       b = 8'hF0;
            2:       b = 8'hE1;
            default: b = 8'($urandom_range(0, 255));
         endcase
         frame(b, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
         total++; if (bus.count !== CW'(exp_q.size())) begin bad++; $display("FAIL rnd_count%0d: got %0d want %0d", n, bus.count, exp_q.size()); end
         total++; if (bus.irq !== (exp_q.size() != 0)) begin bad++; $display("FAIL rnd_irq%0d: got %b want %b", n, bus.irq, exp_q.size() != 0); end
         total++; if (bus.overflow !== m_ovf) begin bad++; $display("FAIL rnd_ovf%0d: got %b want %b", n, bus.overflow, m_ovf); end
         total++; if (bus.err_count !== 8'(m_err)) begin bad++; $display("FAIL rnd_err%0d: got %0d want %0d", n, bus.err_count, m_err); end
         npop = $urandom_range(0, 2);
         for (int j = 0; j < npop; j++) begin
            total++; if (bus.rdata !== exp_head()) begin bad++; $display("FAIL rnd_head%0d: got %h want %h", n, bus.rdata, exp_head()); end
            do_pop();
         end
      end
      while (exp_q.size() > 0) begin
         total++; if (bus.rdata !== exp_head()) begin bad++; $display("FAIL rnd_drain: got %h want %h", bus.rdata, exp_head()); end
         do_pop();
      end
      total++; if (bus.rdata !== 16'h0000) begin bad++; $display("FAIL rnd_empty: got %h want 0000", bus.rdata); end
   endtask

   initial begin
      bus.rd = 1'b0;    bus.clr = 1'b0;
      bus_nb.rd = 1'b0; bus_nb.clr = 1'b0;
      model_clear();
      @(negedge clk);
      test_reset();
      test_make();
      test_break();
      test_errors();
      test_timeout();
      test_overflow();
      test_saturate();
      test_reset_midframe();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
